// File: rtl/alu_design.sv
// alu_design: registered arithmetic/logical ALU with operand qualification.
// Single-cycle ops update all outputs on the next enabled edge. The two
// multiply ops take two enabled edges, and outputs hold in between.
module alu_design #(
    parameter int DW = 8,
    parameter int CW = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            ce_i,
    input  logic            mode_i,
    input  logic [CW-1:0]   cmd_i,
    input  logic [1:0]      inp_valid_i,
    input  logic            cin_i,
    input  logic [DW-1:0]   opa_i,
    input  logic [DW-1:0]   opb_i,
    output logic [2*DW-1:0] res_o,
    output logic            cout_o,
    output logic            err_o,
    output logic            oflow_o,
    output logic            g_o,
    output logic            l_o,
    output logic            e_o
);

    localparam int SW = (DW > 1) ? $clog2(DW) : 1;

    // Arithmetic command codes
    localparam logic [CW-1:0] A_ADD    = CW'(0);
    localparam logic [CW-1:0] A_SUB    = CW'(1);
    localparam logic [CW-1:0] A_ADDC   = CW'(2);
    localparam logic [CW-1:0] A_SUBC   = CW'(3);
    localparam logic [CW-1:0] A_INCA   = CW'(4);
    localparam logic [CW-1:0] A_DECA   = CW'(5);
    localparam logic [CW-1:0] A_INCB   = CW'(6);
    localparam logic [CW-1:0] A_DECB   = CW'(7);
    localparam logic [CW-1:0] A_CMP    = CW'(8);
    localparam logic [CW-1:0] A_MULINC = CW'(9);
    localparam logic [CW-1:0] A_MULSHL = CW'(10);
    localparam logic [CW-1:0] A_SADD   = CW'(11);
    localparam logic [CW-1:0] A_SSUB   = CW'(12);

    // Logical command codes
    localparam logic [CW-1:0] L_AND    = CW'(0);
    localparam logic [CW-1:0] L_NAND   = CW'(1);
    localparam logic [CW-1:0] L_OR     = CW'(2);
    localparam logic [CW-1:0] L_NOR    = CW'(3);
    localparam logic [CW-1:0] L_XOR    = CW'(4);
    localparam logic [CW-1:0] L_XNOR   = CW'(5);
    localparam logic [CW-1:0] L_NOTA   = CW'(6);
    localparam logic [CW-1:0] L_NOTB   = CW'(7);
    localparam logic [CW-1:0] L_SHR1A  = CW'(8);
    localparam logic [CW-1:0] L_SHL1A  = CW'(9);
    localparam logic [CW-1:0] L_SHR1B  = CW'(10);
    localparam logic [CW-1:0] L_SHL1B  = CW'(11);
    localparam logic [CW-1:0] L_ROL    = CW'(12);
    localparam logic [CW-1:0] L_ROR    = CW'(13);

    localparam logic [DW:0]   ONE_W    = (DW+1)'(1);
    localparam logic [SW:0]   DW_L     = (SW+1)'(DW);

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t            state_q;
    logic [2*DW-1:0]   res_q;
    logic              cout_q, err_q, oflow_q, g_q, l_q, e_q;
    logic [DW:0]       mulA_q, mulB_q;

    logic [2*DW-1:0]   res_d;
    logic              cout_d, err_d, oflow_d, g_d, l_d, e_d;
    logic [DW:0]       mulA_d, mulB_d;
    logic              startMul, needA, needB, known, opsOk;

    logic [DW:0]       aExt, bExt, cinExt, sA, sB;
    logic [DW:0]       sum, sumC, diff, diffC, sSum, sDiff;
    logic [SW-1:0]     rotAmt;
    logic [SW:0]       rotInv;
    logic [DW-1:0]     rolOut, rorOut;
    logic              rotErr;
    logic [2*DW-1:0]   prod;

    function automatic logic [2*DW-1:0] zxW(input logic [DW:0] v);
        zxW = {{(DW-1){1'b0}}, v};
    endfunction

    function automatic logic [2*DW-1:0] zxN(input logic [DW-1:0] v);
        zxN = {{DW{1'b0}}, v};
    endfunction

    assign aExt   = {1'b0, opa_i};
    assign bExt   = {1'b0, opb_i};
    assign cinExt = {{DW{1'b0}}, cin_i};
    assign sA     = {opa_i[DW-1], opa_i};
    assign sB     = {opb_i[DW-1], opb_i};
    assign sum    = aExt + bExt;
    assign sumC   = aExt + bExt + cinExt;
    assign diff   = aExt - bExt;
    assign diffC  = aExt - bExt - cinExt;
    assign sSum   = sA + sB;
    assign sDiff  = sA - sB;
    assign rotAmt = opb_i[SW-1:0];
    assign rotInv = DW_L - {1'b0, rotAmt};
    assign rolOut = (opa_i << rotAmt) | (opa_i >> rotInv);
    assign rorOut = (opa_i >> rotAmt) | (opa_i << rotInv);
    assign rotErr = (opb_i >> SW) != '0;
    assign prod   = {{(DW-1){1'b0}}, mulA_q} * {{(DW-1){1'b0}}, mulB_q};

    // Decode the sampled command into next-state outputs or a multiply start
    always_comb begin
        res_d    = '0;
        cout_d   = 1'b0;
        err_d    = 1'b0;
        oflow_d  = 1'b0;
        g_d      = 1'b0;
        l_d      = 1'b0;
        e_d      = 1'b0;
        startMul = 1'b0;
        mulA_d   = aExt + ONE_W;
        mulB_d   = bExt + ONE_W;
        needA    = 1'b1;
        needB    = 1'b1;
        known    = 1'b1;
        if (mode_i) begin
            case (cmd_i)
                A_ADD:    begin res_d = zxW(sum);  cout_d = sum[DW];  end
                A_SUB:    begin res_d = zxW(diff); oflow_d = aExt < bExt; end
                A_ADDC:   begin res_d = zxW(sumC); cout_d = sumC[DW]; end
                A_SUBC:   begin res_d = zxW(diffC); oflow_d = aExt < (bExt + cinExt); end
                A_INCA:   begin res_d = zxW(aExt + ONE_W); needB = 1'b0; end
                A_DECA:   begin res_d = zxW(aExt - ONE_W); needB = 1'b0; end
                A_INCB:   begin res_d = zxW(bExt + ONE_W); needA = 1'b0; end
                A_DECB:   begin res_d = zxW(bExt - ONE_W); needA = 1'b0; end
                A_CMP:    begin g_d = opa_i > opb_i; l_d = opa_i < opb_i; e_d = opa_i == opb_i; end
                A_MULINC: startMul = 1'b1;
                A_MULSHL: begin
                    startMul = 1'b1;
                    mulA_d   = {1'b0, opa_i[DW-2:0], 1'b0};
                    mulB_d   = bExt;
                end
                A_SADD, A_SSUB: begin
                    res_d   = zxW((cmd_i == A_SADD) ? sSum : sDiff);
                    oflow_d = (cmd_i == A_SADD) ? (sSum[DW] != sSum[DW-1])
                                                : (sDiff[DW] != sDiff[DW-1]);
                    g_d = $signed(opa_i) >  $signed(opb_i);
                    l_d = $signed(opa_i) <  $signed(opb_i);
                    e_d = opa_i == opb_i;
                end
                default:  known = 1'b0;
            endcase
        end else begin
            case (cmd_i)
                L_AND:    res_d = zxN(opa_i & opb_i);
                L_NAND:   res_d = zxN(~(opa_i & opb_i));
                L_OR:     res_d = zxN(opa_i | opb_i);
                L_NOR:    res_d = zxN(~(opa_i | opb_i));
                L_XOR:    res_d = zxN(opa_i ^ opb_i);
                L_XNOR:   res_d = zxN(~(opa_i ^ opb_i));
                L_NOTA:   begin res_d = zxN(~opa_i); needB = 1'b0; end
                L_NOTB:   begin res_d = zxN(~opb_i); needA = 1'b0; end
                L_SHR1A:  begin res_d = zxN({1'b0, opa_i[DW-1:1]}); needB = 1'b0; end
                L_SHL1A:  begin res_d = zxN({opa_i[DW-2:0], 1'b0}); needB = 1'b0; end
                L_SHR1B:  begin res_d = zxN({1'b0, opb_i[DW-1:1]}); needA = 1'b0; end
                L_SHL1B:  begin res_d = zxN({opb_i[DW-2:0], 1'b0}); needA = 1'b0; end
                L_ROL:    begin res_d = zxN(rolOut); err_d = rotErr; end
                L_ROR:    begin res_d = zxN(rorOut); err_d = rotErr; end
                default:  known = 1'b0;
            endcase
        end
        opsOk = (!needA || inp_valid_i[0]) && (!needB || inp_valid_i[1]);
        if (!known || !opsOk) begin
            res_d    = '0;
            cout_d   = 1'b0;
            oflow_d  = 1'b0;
            g_d      = 1'b0;
            l_d      = 1'b0;
            e_d      = 1'b0;
            err_d    = 1'b1;
            startMul = 1'b0;
        end
    end

    // Output registers and the two-edge multiply sequencer
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            oflow_q <= 1'b0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            mulA_q  <= '0;
            mulB_q  <= '0;
        end else if (ce_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (startMul) begin
                        mulA_q  <= mulA_d;
                        mulB_q  <= mulB_d;
                        state_q <= ST_MUL;
                    end else begin
                        res_q   <= res_d;
                        cout_q  <= cout_d;
                        err_q   <= err_d;
                        oflow_q <= oflow_d;
                        g_q     <= g_d;
                        l_q     <= l_d;
                        e_q     <= e_d;
                    end
                end
                ST_MUL: begin
                    res_q   <= prod;
                    cout_q  <= 1'b0;
                    err_q   <= 1'b0;
                    oflow_q <= 1'b0;
                    g_q     <= 1'b0;
                    l_q     <= 1'b0;
                    e_q     <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign res_o   = res_q;
    assign cout_o  = cout_q;
    assign err_o   = err_q;
    assign oflow_o = oflow_q;
    assign g_o     = g_q;
    assign l_o     = l_q;
    assign e_o     = e_q;

endmodule

// File: tb/tb_alu_design.sv
// tb_alu_design: directed and randomized checks of alu_design against an
// arithmetic reference model of the ALU's documented behaviour.
module tb_alu_design;

    logic        clk = 1'b0;
    logic        rst_n, ce, mode, cin;
    logic [3:0]  cmd;
    logic [1:0]  iv;
    logic [7:0]  a, b;
    logic [15:0] res_o;
    logic        cout_o, err_o, oflow_o, g_o, l_o, e_o;

    typedef struct packed {
        logic [15:0] res;
        logic        cout, err, oflow, g, l, e;
    } outs_t;

    typedef struct {
        logic       md;
        logic [3:0] c;
        logic [1:0] v;
        logic       ci;
        logic [7:0] x;
        logic [7:0] y;
        outs_t      exp;
    } vec_t;

    int errors = 0;
    int checks = 0;

    alu_design #(.DW(8), .CW(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .mode_i(mode), .cmd_i(cmd),
        .inp_valid_i(iv), .cin_i(cin), .opa_i(a), .opb_i(b),
        .res_o(res_o), .cout_o(cout_o), .err_o(err_o), .oflow_o(oflow_o),
        .g_o(g_o), .l_o(l_o), .e_o(e_o)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic outs_t mk(logic [15:0] r, logic co, logic er, logic of,
                                 logic gg, logic ll, logic ee);
        outs_t o;
        o.res = r; o.cout = co; o.err = er; o.oflow = of; o.g = gg; o.l = ll; o.e = ee;
        return o;
    endfunction

    function automatic outs_t observe();
        return {res_o, cout_o, err_o, oflow_o, g_o, l_o, e_o};
    endfunction

    // Reference model: plain integer arithmetic on the documented op table
    function automatic outs_t refModel(logic md, logic [3:0] cmdIn, logic [1:0] vIn,
                                       logic ciIn, logic [7:0] xIn, logic [7:0] yIn,
                                       output bit isMul);
        outs_t o;
        int c, v, ci, x, y, sx, sy, r, s, need, sh;
        c = {28'd0, cmdIn}; v = {30'd0, vIn}; ci = {31'd0, ciIn};
        x = {24'd0, xIn};   y = {24'd0, yIn};
        sx = (x > 127) ? x - 256 : x;
        sy = (y > 127) ? y - 256 : y;
        o = '0; isMul = 0; r = 0;
        if ((md && c > 12) || (!md && c > 13)) begin o.err = 1'b1; return o; end
        if (md) need = (c == 4 || c == 5) ? 1 : (c == 6 || c == 7) ? 2 : 3;
        else    need = (c == 6 || c == 8 || c == 9) ? 1 : (c == 7 || c == 10 || c == 11) ? 2 : 3;
        if ((v & need) != need) begin o.err = 1'b1; return o; end
        if (md) begin
            case (c)
                0: begin r = x + y; o.cout = r > 255; end
                1: begin r = x - y; o.oflow = x < y; end
                2: begin r = x + y + ci; o.cout = r > 255; end
                3: begin r = x - y - ci; o.oflow = x < y + ci; end
                4: r = x + 1;
                5: r = x - 1;
                6: r = y + 1;
                7: r = y - 1;
                8: begin o.g = x > y; o.l = x < y; o.e = x == y; end
                9: begin r = (x + 1) * (y + 1); isMul = 1; end
                10: begin r = ((x * 2) % 256) * y; isMul = 1; end
                default: begin
                    s = (c == 11) ? sx + sy : sx - sy;
                    r = s;
                    o.oflow = (s > 127) || (s < -128);
                    o.g = sx > sy; o.l = sx < sy; o.e = sx == sy;
                end
            endcase
            o.res = isMul ? 16'(r & 'hFFFF) : 16'(r & 'h1FF);
        end else begin
            sh = y % 8;
            case (c)
                0: r = x & y;
                1: r = ~(x & y);
                2: r = x | y;
                3: r = ~(x | y);
                4: r = x ^ y;
                5: r = ~(x ^ y);
                6: r = ~x;
                7: r = ~y;
                8: r = x >> 1;
                9: r = x << 1;
                10: r = y >> 1;
                11: r = y << 1;
                12: r = (x << sh) | (x >> (8 - sh));
                default: r = (x >> sh) | (x << (8 - sh));
            endcase
            if (c >= 12) o.err = y >= 8;
            o.res = 16'(r & 'hFF);
        end
        return o;
    endfunction

    task automatic applyStimulus(logic e, logic md, logic [3:0] c, logic [1:0] v,
                                 logic ci, logic [7:0] x, logic [7:0] y);
        ce = e; mode = md; cmd = c; iv = v; cin = ci; a = x; b = y;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        outs_t obs;
        rst_n = 1'b1; ce = 1'b0; mode = 1'b0; cmd = '0; iv = '0; cin = 1'b0; a = '0; b = '0;
        #2 rst_n = 1'b0;
        #10;
        obs = observe(); checks++;
        if (obs !== '0) begin errors++; $display("[TB] FAIL reset_state: got %h expected %h", obs, 22'h0); end
        @(negedge clk) rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'd0, 2'b11, 1'b0, 8'hFF, 8'h01);
        applyStimulus(1'b1, 1'b1, 4'd9, 2'b11, 1'b0, 8'd3, 8'd4);
        #2 rst_n = 1'b0;
        #1;
        obs = observe(); checks++;
        if (obs !== '0) begin errors++; $display("[TB] FAIL reset_mid_mul: got %h expected %h", obs, 22'h0); end
        #2 rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'd0, 2'b11, 1'b0, 8'h00, 8'h00);
        obs = observe(); checks++;
        if (obs !== '0) begin errors++; $display("[TB] FAIL reset_mul_discarded: got %h expected %h", obs, 22'h0); end
    endtask

    task automatic test_arith();
        vec_t q[$];
        outs_t obs;
        q.push_back('{1'b1, 4'd0,  2'b11, 1'b0, 8'hFF, 8'h01, mk(16'h0100, 1, 0, 0, 0, 0, 0)});
        q.push_back('{1'b1, 4'd1,  2'b11, 1'b0, 8'd3,  8'd5,  mk(16'h01FE, 0, 0, 1, 0, 0, 0)});
        q.push_back('{1'b1, 4'd2,  2'b11, 1'b1, 8'hFF, 8'h00, mk(16'h0100, 1, 0, 0, 0, 0, 0)});
        q.push_back('{1'b1, 4'd3,  2'b11, 1'b1, 8'd5,  8'd5,  mk(16'h01FF, 0, 0, 1, 0, 0, 0)});
        q.push_back('{1'b1, 4'd4,  2'b01, 1'b0, 8'hFF, 8'h00, mk(16'h0100, 0, 0, 0, 0, 0, 0)});
        q.push_back('{1'b1, 4'd5,  2'b01, 1'b0, 8'h00, 8'h00, mk(16'h01FF, 0, 0, 0, 0, 0, 0)});
        q.push_back('{1'b1, 4'd6,  2'b10, 1'b0, 8'h00, 8'h07, mk(16'h0008, 0, 0, 0, 0, 0, 0)});
        q.push_back('{1'b1, 4'd7,  2'b10, 1'b0, 8'h00, 8'h00, mk(16'h01FF, 0, 0, 0, 0, 0, 0)});
        q.push_back('{1'b1, 4'd11, 2'b11, 1'b0, 8'h7F, 8'h01, mk(16'h0080, 0, 0, 1, 1, 0, 0)});
        q.push_back('{1'b1, 4'd12, 2'b11, 1'b0, 8'h80, 8'h01, mk(16'h017F, 0, 0, 1, 0, 1, 0)});
        q.push_back('{1'b1, 4'd8,  2'b11, 1'b0, 8'h5A, 8'h5A, mk(16'h0000, 0, 0, 0, 0, 0, 1)});
        q.push_back('{1'b1, 4'd8,  2'b11, 1'b0, 8'h10, 8'h20, mk(16'h0000, 0, 0, 0, 0, 1, 0)});
        q.push_back('{1'b1, 4'd8,  2'b11, 1'b0, 8'h20, 8'h10, mk(16'h0000, 0, 0, 0, 1, 0, 0)});
        foreach (q[i]) begin
            applyStimulus(1'b1, q[i].md, q[i].c, q[i].v, q[i].ci, q[i].x, q[i].y);
            obs = observe(); checks++;
            if (obs !== q[i].exp) begin
                errors++;
                $display("[TB] FAIL arith[%0d] cmd=%0d: got %h expected %h", i, q[i].c, obs, q[i].exp);
            end
        end
    endtask

    task automatic test_mul();
        outs_t obs, prior, want;
        prior = mk(16'h0000, 0, 0, 0, 0, 1, 0);
        applyStimulus(1'b1, 1'b1, 4'd8, 2'b11, 1'b0, 8'h10, 8'h20);
        applyStimulus(1'b1, 1'b1, 4'd9, 2'b11, 1'b0, 8'd3, 8'd4);
        obs = observe(); checks++;
        if (obs !== prior) begin errors++; $display("[TB] FAIL mul_inc_hold: got %h expected %h", obs, prior); end
        applyStimulus(1'b1, 1'b1, 4'd0, 2'b11, 1'b0, 8'd1, 8'd1);
        want = mk(16'd20, 0, 0, 0, 0, 0, 0); obs = observe(); checks++;
        if (obs !== want) begin errors++; $display("[TB] FAIL mul_inc_result: got %h expected %h", obs, want); end
        applyStimulus(1'b1, 1'b1, 4'd10, 2'b11, 1'b0, 8'h81, 8'h02);
        obs = observe(); checks++;
        if (obs !== want) begin errors++; $display("[TB] FAIL mul_shl_hold: got %h expected %h", obs, want); end
        applyStimulus(1'b1, 1'b0, 4'd6, 2'b01, 1'b0, 8'h0F, 8'h00);
        want = mk(16'h0004, 0, 0, 0, 0, 0, 0); obs = observe(); checks++;
        if (obs !== want) begin errors++; $display("[TB] FAIL mul_shl_result: got %h expected %h", obs, want); end
        applyStimulus(1'b1, 1'b1, 4'd9, 2'b11, 1'b0, 8'h0F, 8'h0F);
        applyStimulus(1'b0, 1'b1, 4'd0, 2'b11, 1'b0, 8'h01, 8'h01);
        applyStimulus(1'b0, 1'b0, 4'd3, 2'b11, 1'b0, 8'h00, 8'h00);
        obs = observe(); checks++;
        if (obs !== want) begin errors++; $display("[TB] FAIL mul_stall_hold: got %h expected %h", obs, want); end
        applyStimulus(1'b1, 1'b0, 4'd3, 2'b11, 1'b0, 8'h00, 8'h00);
        want = mk(16'h0100, 0, 0, 0, 0, 0, 0); obs = observe(); checks++;
        if (obs !== want) begin errors++; $display("[TB] FAIL mul_stall_result: got %h expected %h", obs, want); end
    endtask

    task automatic test_logical();
        vec_t q[$];
        outs_t obs;
        q.push_back('{1'b0, 4'd12, 2'b11, 1'b0, 8'h81, 8'h01, mk(16'h0003, 0, 0, 0, 0, 0, 0)});
        q.push_back('{1'b0, 4'd12, 2'b11, 1'b0, 8'h81, 8'h10, mk(16'h0081, 0, 1, 0, 0, 0, 0)});
        q.push_back('{1'b0, 4'd13, 2'b11, 1'b0, 8'h81, 8'h01, mk(16'h00C0, 0, 0, 0, 0, 0, 0)});
        q.push_back('{1'b0, 4'd6,  2'b01, 1'b0, 8'h0F, 8'h00, mk(16'h00F0, 0, 0, 0, 0, 0, 0)});
        q.push_back('{1'b0, 4'd7,  2'b10, 1'b0, 8'h00, 8'h3C, mk(16'h00C3, 0, 0, 0, 0, 0, 0)});
        q.push_back('{1'b0, 4'd1,  2'b11, 1'b0, 8'hF0, 8'h3C, mk(16'h00CF, 0, 0, 0, 0, 0, 0)});
        q.push_back('{1'b0, 4'd5,  2'b11, 1'b0, 8'hF0, 8'h3C, mk(16'h0033, 0, 0, 0, 0, 0, 0)});
        q.push_back('{1'b0, 4'd9,  2'b01, 1'b0, 8'h81, 8'h00, mk(16'h0002, 0, 0, 0, 0, 0, 0)});
        q.push_back('{1'b0, 4'd10, 2'b10, 1'b0, 8'h00, 8'h81, mk(16'h0040, 0, 0, 0, 0, 0, 0)});
        q.push_back('{1'b0, 4'd3,  2'b11, 1'b0, 8'h00, 8'h00, mk(16'h00FF, 0, 0, 0, 0, 0, 0)});
        foreach (q[i]) begin
            applyStimulus(1'b1, q[i].md, q[i].c, q[i].v, q[i].ci, q[i].x, q[i].y);
            obs = observe(); checks++;
            if (obs !== q[i].exp) begin
                errors++;
                $display("[TB] FAIL logical[%0d] cmd=%0d: got %h expected %h", i, q[i].c, obs, q[i].exp);
            end
        end
    endtask

    task automatic test_errors();
        vec_t q[$];
        outs_t obs, want;
        want = mk(16'h0000, 0, 1, 0, 0, 0, 0);
        q.push_back('{1'b1, 4'd0,  2'b01, 1'b0, 8'hFF, 8'h01, want});
        q.push_back('{1'b1, 4'd15, 2'b11, 1'b0, 8'h12, 8'h34, want});
        q.push_back('{1'b0, 4'd14, 2'b11, 1'b0, 8'h12, 8'h34, want});
        q.push_back('{1'b1, 4'd4,  2'b10, 1'b0, 8'h12, 8'h34, want});
        q.push_back('{1'b0, 4'd6,  2'b00, 1'b0, 8'h12, 8'h34, want});
        q.push_back('{1'b0, 4'd11, 2'b01, 1'b0, 8'h12, 8'h34, want});
        foreach (q[i]) begin
            applyStimulus(1'b1, 1'b1, 4'd0, 2'b11, 1'b0, 8'h01, 8'h01);
            applyStimulus(1'b1, q[i].md, q[i].c, q[i].v, q[i].ci, q[i].x, q[i].y);
            obs = observe(); checks++;
            if (obs !== q[i].exp) begin
                errors++;
                $display("[TB] FAIL error[%0d] cmd=%0d: got %h expected %h", i, q[i].c, obs, q[i].exp);
            end
        end
        applyStimulus(1'b0, 1'b1, 4'd0, 2'b11, 1'b0, 8'hFF, 8'hFF);
        obs = observe(); checks++;
        if (obs !== want) begin errors++; $display("[TB] FAIL ce_hold: got %h expected %h", obs, want); end
    endtask

    task automatic test_random();
        outs_t obs, exp, pend, o;
        bit pending, isMul;
        logic e, md, ci;
        logic [3:0] c;
        logic [1:0] v;
        logic [7:0] x, y;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        exp = '0; pending = 0; pend = '0;
        for (int n = 0; n < 400; n++) begin
            e  = ($urandom_range(0, 9) != 0);
            md = 1'($urandom_range(0, 1));
            c  = 4'($urandom_range(0, 15));
            v  = ($urandom_range(0, 7) < 5) ? 2'b11 : 2'($urandom_range(0, 2));
            ci = 1'($urandom_range(0, 1));
            x  = 8'($urandom);
            y  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            if (e) begin
                if (pending) begin
                    exp = pend; pending = 0;
                end else begin
                    o = refModel(md, c, v, ci, x, y, isMul);
                    if (isMul) begin pend = o; pending = 1; end
                    else exp = o;
                end
            end
            applyStimulus(e, md, c, v, ci, x, y);
            obs = observe(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL random[%0d] ce=%0d mode=%0d cmd=%0d iv=%b a=%h b=%h: got %h expected %h",
                         n, e, md, c, v, x, y, obs, exp);
            end
        end
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_arith();
        test_mul();
        test_logical();
        test_errors();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
